// File: rtl/uart_core_cfg.sv
// uart_core_cfg: parametrised full-duplex UART core.
// Shared free-running baud tick, TX and RX three-process FSMs.
// The RX path adds a 2-flop synchroniser, mid-bit sampling, false-start
// rejection, and parity/framing error reporting.
module uart_core_cfg #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD_RATE  = 19200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data_in,
    input  logic                 start,
    output logic                 tx,
    output logic                 tx_active,
    output logic                 done_tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data_out,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err
);

    localparam int unsigned DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OW  = $clog2(OVERSAMPLE);
    localparam int unsigned BW  = 4;

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0] OS_HALF   = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    // Elaboration-time parameter legality checks
    if (DIV < 2) begin : g_chk_div
        $error("uart_core_cfg: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
        $error("uart_core_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY > 2) begin : g_chk_par
        $error("uart_core_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
        $error("uart_core_cfg: STOP_BITS must be 1 or 2");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_chk_os
        $error("uart_core_cfg: OVERSAMPLE must be even and >= 8");
    end

    // ------------------------------------------------------------------
    // Baud tick
    // ------------------------------------------------------------------
    logic [TW-1:0] r_tick_cnt;
    logic          w_tick;

    assign w_tick = (r_tick_cnt == TICK_LAST);

    // Free-running divider, one-cycle tick at wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_tick_cnt <= '0;
        else if (w_tick)
            r_tick_cnt <= '0;
        else
            r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    tx_state_t              r_tx_state;
    tx_state_t              w_tx_next;
    logic [OW-1:0]          r_tx_os;
    logic [BW-1:0]          r_tx_bit;
    logic [DATA_BITS-1:0]   r_tx_shift;
    logic                   r_tx_par;
    logic                   r_done_tx;
    logic                   w_tx_accept;
    logic                   w_tx_bit_end;

    assign w_tx_accept  = (r_tx_state == TX_IDLE) && start;
    assign w_tx_bit_end = (r_tx_state != TX_IDLE) && w_tick && (r_tx_os == OS_LAST);

    // TX state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_tx_state <= TX_IDLE;
        else
            r_tx_state <= w_tx_next;
    end

    // TX next-state logic
    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE:   if (start) w_tx_next = TX_START;
            TX_START:  if (w_tx_bit_end) w_tx_next = TX_DATA;
            TX_DATA:   if (w_tx_bit_end && (r_tx_bit == DATA_LAST))
                           w_tx_next = (PARITY != 0) ? TX_PARITY : TX_STOP;
            TX_PARITY: if (w_tx_bit_end) w_tx_next = TX_STOP;
            TX_STOP:   if (w_tx_bit_end && (r_tx_bit == STOP_LAST)) w_tx_next = TX_IDLE;
            default:   w_tx_next = TX_IDLE;
        endcase
    end

    // TX outputs decoded from state; idle line is high
    always_comb begin
        tx        = 1'b1;
        tx_active = (r_tx_state != TX_IDLE);
        case (r_tx_state)
            TX_START:  tx = 1'b0;
            TX_DATA:   tx = r_tx_shift[0];
            TX_PARITY: tx = r_tx_par;
            default:   tx = 1'b1;
        endcase
    end

    // TX datapath: payload latch, oversample/bit counters, done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_os    <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_done_tx  <= 1'b0;
        end else begin
            r_done_tx <= (r_tx_state == TX_STOP) && w_tx_bit_end && (r_tx_bit == STOP_LAST);
            if (w_tx_accept) begin
                r_tx_shift <= tx_data_in;
                r_tx_par   <= (PARITY == 1) ? ~(^tx_data_in) : (^tx_data_in);
                r_tx_os    <= '0;
                r_tx_bit   <= '0;
            end else if ((r_tx_state != TX_IDLE) && w_tick) begin
                if (w_tx_bit_end) begin
                    r_tx_os <= '0;
                    if (r_tx_state == TX_DATA) begin
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_bit   <= (r_tx_bit == DATA_LAST) ? '0 : r_tx_bit + 1'b1;
                    end else if (r_tx_state == TX_STOP) begin
                        r_tx_bit <= r_tx_bit + 1'b1;
                    end else begin
                        r_tx_bit <= '0;
                    end
                end else begin
                    r_tx_os <= r_tx_os + 1'b1;
                end
            end
        end
    end

    assign done_tx = r_done_tx;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    rx_state_t              r_rx_state;
    rx_state_t              w_rx_next;
    logic                   r_rx_meta;
    logic                   r_rx_s;
    logic                   r_rx_s_d;
    logic [OW-1:0]          r_rx_os;
    logic [BW-1:0]          r_rx_bit;
    logic [DATA_BITS-1:0]   r_rx_shift;
    logic                   r_rx_par;
    logic [DATA_BITS-1:0]   r_rx_data;
    logic                   r_rx_valid;
    logic                   r_parity_err;
    logic                   r_frame_err;
    logic                   w_rx_fall;
    logic                   w_rx_half_smp;
    logic                   w_rx_full_smp;
    logic                   w_rx_data_smp;
    logic                   w_rx_par_smp;
    logic                   w_rx_stop_smp;
    logic                   w_rx_par_exp;

    assign w_rx_fall    = r_rx_s_d & ~r_rx_s;
    assign w_rx_par_exp = (PARITY == 1) ? ~(^r_rx_shift) : (^r_rx_shift);

    // Two-flop synchroniser plus one delay stage for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_s_d  <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_s_d  <= r_rx_s;
        end
    end

    // RX state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rx_state <= RX_IDLE;
        else
            r_rx_state <= w_rx_next;
    end

    // RX next-state logic; a held-low line never re-arms since no falling edge is seen
    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:   if (w_rx_fall) w_rx_next = RX_START;
            RX_START:  if (w_rx_half_smp) w_rx_next = r_rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:   if (w_rx_full_smp && (r_rx_bit == DATA_LAST))
                           w_rx_next = (PARITY != 0) ? RX_PARITY : RX_STOP;
            RX_PARITY: if (w_rx_full_smp) w_rx_next = RX_STOP;
            RX_STOP:   if (w_rx_full_smp) w_rx_next = RX_IDLE;
            default:   w_rx_next = RX_IDLE;
        endcase
    end

    // RX sample strobes decoded from state and counters
    always_comb begin
        w_rx_half_smp = (r_rx_state == RX_START) && w_tick && (r_rx_os == OS_HALF);
        w_rx_full_smp = ((r_rx_state == RX_DATA) || (r_rx_state == RX_PARITY) ||
                         (r_rx_state == RX_STOP)) && w_tick && (r_rx_os == OS_LAST);
        w_rx_data_smp = w_rx_full_smp && (r_rx_state == RX_DATA);
        w_rx_par_smp  = w_rx_full_smp && (r_rx_state == RX_PARITY);
        w_rx_stop_smp = w_rx_full_smp && (r_rx_state == RX_STOP);
    end

    // RX datapath: counters, shift-in, result and error flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_os      <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_par     <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_valid <= w_rx_stop_smp;
            if (r_rx_state == RX_IDLE) begin
                if (w_rx_fall) begin
                    r_rx_os  <= '0;
                    r_rx_bit <= '0;
                end
            end else if (w_tick) begin
                if (w_rx_half_smp || w_rx_full_smp)
                    r_rx_os <= '0;
                else
                    r_rx_os <= r_rx_os + 1'b1;
            end
            if (w_rx_data_smp) begin
                r_rx_shift <= {r_rx_s, r_rx_shift[DATA_BITS-1:1]};
                r_rx_bit   <= r_rx_bit + 1'b1;
            end
            if (w_rx_par_smp)
                r_rx_par <= r_rx_s;
            if (w_rx_stop_smp) begin
                r_rx_data    <= r_rx_shift;
                r_frame_err  <= ~r_rx_s;
                r_parity_err <= (PARITY != 0) && (r_rx_par != w_rx_par_exp);
            end
        end
    end

    assign rx_data_out = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign parity_err  = r_parity_err;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_uart_core_cfg.sv
// Directed bench for uart_core_cfg: three instances (8N1, 8E1 loopback,
// 8O1 driven RX) at DIV=10, 160 clk per bit.
module tb_uart_core_cfg;

    localparam int BIT_CLK = 160;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // 8N1 instance
    logic [7:0] n_txd = '0;
    logic       n_start = 1'b0;
    logic       n_tx, n_act, n_done;
    logic       n_rx = 1'b1;
    logic [7:0] n_rxd;
    logic       n_rv, n_pe, n_fe;

    // 8E1 instance, tx looped back to rx
    logic [7:0] e_txd = '0;
    logic       e_start = 1'b0;
    logic       e_tx, e_act, e_done;
    logic [7:0] e_rxd;
    logic       e_rv, e_pe, e_fe;

    // 8O1 instance, rx driven by the bench
    logic [7:0] o_txd = '0;
    logic       o_start = 1'b0;
    logic       o_tx, o_act, o_done;
    logic       o_rx = 1'b1;
    logic [7:0] o_rxd;
    logic       o_rv, o_pe, o_fe;

    uart_core_cfg #(.CLK_FREQ(1600000), .BAUD_RATE(10000), .DATA_BITS(8),
                    .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)) u_n (
        .clk(clk), .rst(rst), .tx_data_in(n_txd), .start(n_start), .tx(n_tx),
        .tx_active(n_act), .done_tx(n_done), .rx(n_rx), .rx_data_out(n_rxd),
        .rx_valid(n_rv), .parity_err(n_pe), .frame_err(n_fe));

    uart_core_cfg #(.CLK_FREQ(1600000), .BAUD_RATE(10000), .DATA_BITS(8),
                    .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16)) u_e (
        .clk(clk), .rst(rst), .tx_data_in(e_txd), .start(e_start), .tx(e_tx),
        .tx_active(e_act), .done_tx(e_done), .rx(e_tx), .rx_data_out(e_rxd),
        .rx_valid(e_rv), .parity_err(e_pe), .frame_err(e_fe));

    uart_core_cfg #(.CLK_FREQ(1600000), .BAUD_RATE(10000), .DATA_BITS(8),
                    .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(16)) u_o (
        .clk(clk), .rst(rst), .tx_data_in(o_txd), .start(o_start), .tx(o_tx),
        .tx_active(o_act), .done_tx(o_done), .rx(o_rx), .rx_data_out(o_rxd),
        .rx_valid(o_rv), .parity_err(o_pe), .frame_err(o_fe));

    int n_cmp = 0;
    int n_bad = 0;
    int n_rv_cnt = 0;
    int e_rv_cnt = 0;
    int o_rv_cnt = 0;

    // rx_valid pulse counters
    always @(negedge clk) begin
        if (n_rv === 1'b1) n_rv_cnt++;
        if (e_rv === 1'b1) e_rv_cnt++;
        if (o_rv === 1'b1) o_rv_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive nb bits LSB first onto n_rx (which==0) or o_rx (which==1)
    task automatic drive(input int which, input logic [10:0] bits, input int nb);
        for (int i = 0; i < nb; i++) begin
            if (which == 0) n_rx = bits[i];
            else            o_rx = bits[i];
            repeat (BIT_CLK) @(negedge clk);
        end
    endtask

    // Send one 8N1 frame on u_n and check line, tx_active and done_tx timing
    task automatic tx_frame_check(input logic [7:0] d, input bit poke);
        logic [9:0] exp_bits;
        int c;
        exp_bits = {1'b1, d, 1'b0};
        c = 0;
        n_txd   = d;
        n_start = 1'b1;
        @(negedge clk);
        n_start = 1'b0;
        chk("tx_active_after_accept", n_act, 1);
        for (int k = 0; k < 10; k++) begin
            while (c < 80 + BIT_CLK * k) begin
                @(negedge clk);
                c++;
            end
            chk($sformatf("tx_bit%0d_of_%02h", k, d), n_tx, exp_bits[k]);
            chk($sformatf("tx_active_bit%0d", k), n_act, 1);
            if (poke && k == 4) begin
                n_txd   = ~d;
                n_start = 1'b1;
                @(negedge clk);
                c++;
                n_start = 1'b0;
                n_txd   = d;
            end
        end
        while (n_done !== 1'b1 && c < 1700) begin
            @(negedge clk);
            c++;
        end
        n_cmp++;
        assert (c >= 1591 && c <= 1600) else begin
            n_bad++;
            $error("FAIL tx_done_time: observed %0d clk expected 1591..1600", c);
        end
        chk("tx_active_low_at_done", n_act, 0);
        @(negedge clk);
        chk("done_tx_one_cycle", n_done, 0);
        repeat (200) @(negedge clk);
        chk("tx_no_queued_frame", n_act, 0);
        chk("tx_idle_high", n_tx, 1);
    endtask

    initial begin
        logic [10:0] fr;
        int base;
        int i;

        // Reset values
        repeat (5) @(negedge clk);
        chk("rst_tx", n_tx, 1);
        chk("rst_tx_active", n_act, 0);
        chk("rst_done_tx", n_done, 0);
        chk("rst_rx_valid", n_rv, 0);
        chk("rst_parity_err", n_pe, 0);
        chk("rst_frame_err", n_fe, 0);
        chk("rst_rx_data", n_rxd, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // 8N1 transmit of A5, with an ignored start mid-frame
        tx_frame_check(8'hA5, 1'b1);

        // Even-parity loopback of 3C
        base    = e_rv_cnt;
        e_txd   = 8'h3C;
        e_start = 1'b1;
        @(negedge clk);
        e_start = 1'b0;
        i = 0;
        while (e_rv_cnt == base && i < 2500) begin
            @(negedge clk);
            i++;
        end
        chk("loop_rx_valid", e_rv_cnt, base + 1);
        chk("loop_rx_data", e_rxd, 8'h3C);
        chk("loop_parity_err", e_pe, 0);
        chk("loop_frame_err", e_fe, 0);
        i = 0;
        while (e_act === 1'b1 && i < 500) begin
            @(negedge clk);
            i++;
        end
        chk("loop_tx_finished", e_act, 0);

        // Odd parity: correct frame then inverted parity bit, back to back
        base = o_rv_cnt;
        fr = {1'b1, 1'b1, 8'h3C, 1'b0};
        drive(1, fr, 11);
        chk("odd_good_valid", o_rv_cnt, base + 1);
        chk("odd_good_data", o_rxd, 8'h3C);
        chk("odd_good_parity_err", o_pe, 0);
        fr = {1'b1, 1'b0, 8'h3C, 1'b0};
        drive(1, fr, 11);
        chk("odd_bad_valid", o_rv_cnt, base + 2);
        chk("odd_bad_data", o_rxd, 8'h3C);
        chk("odd_bad_parity_err", o_pe, 1);
        chk("odd_bad_frame_err", o_fe, 0);

        // Stop bit low on 55, then break for 3 frames
        base = n_rv_cnt;
        fr = {1'b0, 1'b0, 8'h55, 1'b0};
        drive(0, fr, 10);
        chk("ferr_valid", n_rv_cnt, base + 1);
        chk("ferr_data", n_rxd, 8'h55);
        chk("ferr_frame_err", n_fe, 1);
        chk("ferr_parity_err", n_pe, 0);
        repeat (3 * 10 * BIT_CLK) @(negedge clk);
        chk("break_no_valid", n_rv_cnt, base + 1);
        n_rx = 1'b1;
        repeat (300) @(negedge clk);
        chk("break_release_no_valid", n_rv_cnt, base + 1);

        // 40-clk glitch rejected, then valid 81 frame
        n_rx = 1'b0;
        repeat (40) @(negedge clk);
        n_rx = 1'b1;
        repeat (200) @(negedge clk);
        chk("glitch_no_valid", n_rv_cnt, base + 1);
        fr = {1'b1, 1'b1, 8'h81, 1'b0};
        drive(0, fr, 10);
        chk("after_glitch_valid", n_rv_cnt, base + 2);
        chk("after_glitch_data", n_rxd, 8'h81);
        chk("after_glitch_frame_err", n_fe, 0);
        chk("after_glitch_parity_err", n_pe, 0);

        // Asynchronous reset mid-DATA while sending FF
        n_txd   = 8'hFF;
        n_start = 1'b1;
        @(negedge clk);
        n_start = 1'b0;
        repeat (3 * BIT_CLK) @(negedge clk);
        chk("pre_rst_tx_active", n_act, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_tx", n_tx, 1);
        chk("async_rst_tx_active", n_act, 0);
        chk("async_rst_rx_data", n_rxd, 0);
        chk("async_rst_loop_rx_data", e_rxd, 0);
        chk("async_rst_odd_parity_err", o_pe, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        tx_frame_check(8'hFF, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
